// File: rtl/spi_crc_bus_bridge.sv
// SPI-slave (mode 0, oversampled) to register-bus bridge with CRC-8 protected frames.
// Frame: {rw, addr[ADDR_W], crc[8], data[DATA_W]}, MSB first, no chip select.
// Optional build macro: SPI_BRIDGE_CRC_CHECK_EN -- when defined, write frames whose CRC field
// does not match crc8(CRC_INIT, data) are dropped and counted in crc_err_cnt_o.
// Assumes ADDR_W >= 1 and DATA_W >= 2.
module spi_crc_bus_bridge #(
  parameter int          ADDR_W   = 15,
  parameter int          DATA_W   = 16,
  parameter int          RD_LAT   = 1,
  parameter int          IDLE_TO  = 64,
  parameter logic [7:0]  CRC_INIT = 8'h9C
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic              bus_we_o,
  output logic              bus_re_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              frame_err_o,
  output logic [7:0]        crc_err_cnt_o
);

  localparam int HDR_W = 1 + ADDR_W;
  localparam int RSP_W = 8 + DATA_W;
  localparam int CNT_W = $clog2(RSP_W + 1);
  localparam int TO_W  = $clog2(IDLE_TO + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_COMMIT,
    S_RD_WAIT,
    S_RESP
  } state_t;

  // One MSB-first step of CRC-8, polynomial x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? 8'h07 : 8'h00);
  endfunction

  // CRC-8 of a whole data word, seeded with CRC_INIT.
  function automatic logic [7:0] crc8_word(input logic [DATA_W-1:0] word);
    logic [7:0] crc;
    crc = CRC_INIT;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      crc = crc8_step(crc, word[i]);
    end
    crc8_word = crc;
  endfunction

  state_t              state_q, state_d;
  logic                sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
  logic                mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   hdr_sr_q, hdr_sr_d;
  logic [DATA_W-2:0]   data_sr_q, data_sr_d;
  logic [RSP_W-1:0]    tx_sr_q, tx_sr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                re_q, re_d;
  logic                frame_err_q, frame_err_d;
  logic                spi_edge;
  logic                mosi_bit;
  logic                timeout;
  logic                commit_ok;
  logic [HDR_W-1:0]    hdr_shift;
  logic [DATA_W-1:0]   data_shift;

`ifdef SPI_BRIDGE_CRC_CHECK_EN
  logic [7:0] crc_rx_q, crc_rx_d;
  logic [7:0] crc_run_q, crc_run_d;
  logic [7:0] crc_err_q, crc_err_d;

  assign commit_ok     = (crc_rx_q == crc_run_q);
  assign crc_err_cnt_o = crc_err_q;
`else
  assign commit_ok     = 1'b1;
  assign crc_err_cnt_o = 8'd0;
`endif

  assign spi_edge  = sclk_s2_q & ~sclk_prev_q;
  assign mosi_bit  = mosi_s2_q;
  assign hdr_shift = {hdr_sr_q, mosi_bit};
  assign data_shift = {data_sr_q, mosi_bit};

  assign spi_miso_o  = (state_q == S_RESP) ? tx_sr_q[RSP_W-1] : 1'b0;
  assign bus_we_o    = (state_q == S_COMMIT) && commit_ok;
  assign bus_re_o    = re_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign frame_err_o = frame_err_q;

  // Next-state logic: synchroniser, frame FSM, idle timeout and bus strobes.
  always_comb begin
    sclk_s1_d   = spi_clk_i;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    mosi_s1_d   = spi_mosi_i;
    mosi_s2_d   = mosi_s1_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    hdr_sr_d    = hdr_sr_q;
    data_sr_d   = data_sr_q;
    tx_sr_d     = tx_sr_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    re_d        = 1'b0;
    frame_err_d = 1'b0;
`ifdef SPI_BRIDGE_CRC_CHECK_EN
    crc_rx_d    = crc_rx_q;
    crc_run_d   = crc_run_q;
    crc_err_d   = crc_err_q;
`endif

    // The counter measures clk_i cycles since the last SPI edge; an edge always wins.
    timeout = 1'b0;
    if (spi_edge || state_q == S_IDLE) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (state_q != S_COMMIT && to_cnt_q == TO_W'(IDLE_TO - 1)) begin
        timeout = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (spi_edge) begin
          hdr_sr_d  = hdr_shift[ADDR_W-1:0];
          bit_cnt_d = CNT_W'(1);
          state_d   = S_HDR;
        end
      end

      S_HDR: begin
        if (spi_edge) begin
          hdr_sr_d  = hdr_shift[ADDR_W-1:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(HDR_W - 1)) begin
            addr_d    = hdr_shift[ADDR_W-1:0];
            bit_cnt_d = '0;
            if (hdr_shift[ADDR_W]) begin
              state_d = S_WDATA;
`ifdef SPI_BRIDGE_CRC_CHECK_EN
              crc_run_d = CRC_INIT;
`endif
            end else begin
              state_d = S_RD_WAIT;
              re_d    = 1'b1;
              lat_d   = '0;
            end
          end
        end
      end

      S_WDATA: begin
        if (spi_edge) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < CNT_W'(8)) begin
`ifdef SPI_BRIDGE_CRC_CHECK_EN
            crc_rx_d = {crc_rx_q[6:0], mosi_bit};
`endif
          end else begin
            data_sr_d = data_shift[DATA_W-2:0];
`ifdef SPI_BRIDGE_CRC_CHECK_EN
            crc_run_d = crc8_step(crc_run_q, mosi_bit);
`endif
          end
          if (bit_cnt_q == CNT_W'(RSP_W - 1)) begin
            wdata_d = data_shift;
            state_d = S_COMMIT;
          end
        end
      end

      S_COMMIT: begin
        // The write strobe is decoded from this state; only the error count lives here.
`ifdef SPI_BRIDGE_CRC_CHECK_EN
        if (!commit_ok && crc_err_q != 8'hFF) begin
          crc_err_d = crc_err_q + 8'd1;
        end
`endif
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end

      S_RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          tx_sr_d   = {bus_rdata_i, crc8_word(bus_rdata_i)};
          bit_cnt_d = '0;
          state_d   = S_RESP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      S_RESP: begin
        if (spi_edge) begin
          tx_sr_d   = {tx_sr_q[RSP_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(RSP_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end
      end

      default: begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    if (timeout) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      to_cnt_d    = '0;
      re_d        = 1'b0;
      frame_err_d = 1'b1;
    end
  end

  // State registers; reset clears everything and discards any frame in flight.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      bit_cnt_q   <= '0;
      hdr_sr_q    <= '0;
      data_sr_q   <= '0;
      tx_sr_q     <= '0;
      lat_q       <= '0;
      to_cnt_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      re_q        <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_BRIDGE_CRC_CHECK_EN
      crc_rx_q    <= '0;
      crc_run_q   <= '0;
      crc_err_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      mosi_s1_q   <= mosi_s1_d;
      mosi_s2_q   <= mosi_s2_d;
      bit_cnt_q   <= bit_cnt_d;
      hdr_sr_q    <= hdr_sr_d;
      data_sr_q   <= data_sr_d;
      tx_sr_q     <= tx_sr_d;
      lat_q       <= lat_d;
      to_cnt_q    <= to_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      re_q        <= re_d;
      frame_err_q <= frame_err_d;
`ifdef SPI_BRIDGE_CRC_CHECK_EN
      crc_rx_q    <= crc_rx_d;
      crc_run_q   <= crc_run_d;
      crc_err_q   <= crc_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_crc_bus_bridge.sv
// Self-checking bench for spi_crc_bus_bridge: directed scenarios plus random frames, with a
// scoreboard of expected bus events and expected MISO responses.
module tb_spi_crc_bus_bridge;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;
  localparam int IDLE_TO = 64;
  localparam logic [7:0] CRC_INIT = 8'h9C;
  localparam int H = 6;  // clk_i cycles per SPI clock phase
`ifdef SPI_BRIDGE_CRC_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              spi_clk_i = 1'b0;
  logic              spi_mosi_i = 1'b0;
  logic              spi_miso_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_we_o;
  logic              bus_re_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              frame_err_o;
  logic [7:0]        crc_err_cnt_o;

  spi_crc_bus_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .IDLE_TO(IDLE_TO), .CRC_INIT(CRC_INIT)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .spi_clk_i(spi_clk_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_we_o(bus_we_o), .bus_re_o(bus_re_o), .bus_rdata_i(bus_rdata_i),
    .frame_err_o(frame_err_o), .crc_err_cnt_o(crc_err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Bus slave model: read data is only valid RD_LAT cycles after the read strobe.
  logic [7:0]        re_pipe = 8'h00;
  logic [DATA_W-1:0] rd_value = '0;
  always @(posedge clk_i) re_pipe <= {re_pipe[6:0], bus_re_o};
  assign bus_rdata_i = re_pipe[RD_LAT-1] ? rd_value : 16'hDEAD;

  typedef struct {
    int                kind;  // 0 write, 1 read, 2 frame error
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [39:0] miso_exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          crc_err_model = 0;
  bit          rd_active = 1'b0;

  // CRC-8 as polynomial long division: remainder of (INIT*x^16 + D*x^8) mod 0x107.
  function automatic logic [7:0] crc8_ref(input logic [15:0] d);
    logic [23:0] v;
    v = {CRC_INIT, 16'h0000} ^ {d, 8'h00};
    for (int b = 23; b >= 8; b--) begin
      if (v[b]) v[b -: 9] = v[b -: 9] ^ 9'h107;
    end
    return v[7:0];
  endfunction

  task automatic check_ev(input int kind, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required none", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != 2 && e.addr != addr) || (kind == 0 && e.data != data)) begin
        n_fail++;
        $display("FAIL bus_event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end else begin
        $display("event ok kind=%0d addr=%h data=%h", kind, addr, data);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  initial forever begin
    @(negedge clk_i);
    if (reset_i) begin
      if (bus_we_o)    check_ev(0, bus_addr_o, bus_wdata_o);
      if (bus_re_o)    check_ev(1, bus_addr_o, '0);
      if (frame_err_o) check_ev(2, '0, '0);
    end
  end

  // MISO monitor: host-side capture at each SPI rising edge during read frames.
  initial begin
    logic [39:0] rx;
    logic [39:0] ex;
    int          rx_n;
    rx = '0;
    rx_n = 0;
    forever begin
      @(posedge spi_clk_i);
      if (!rd_active) begin
        rx_n = 0;
      end else begin
        rx = {rx[38:0], spi_miso_o};
        rx_n++;
        if (rx_n == 40) begin
          rx_n = 0;
          n_checks++;
          if (miso_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL miso_frame: got %h, required nothing", rx);
          end else begin
            ex = miso_exp_q.pop_front();
            if (rx != ex) begin
              n_fail++;
              $display("FAIL miso_frame: got %h, required %h", rx, ex);
            end else begin
              $display("miso ok %h", rx);
            end
          end
        end
      end
    end
  end

  // Host: shift out the first nbits of a 40-bit frame, optional gap after every gap_every bits.
  task automatic spi_send(input logic [39:0] bits, input int nbits, input int gap_every);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = bits[39-i];
      repeat (H) @(negedge clk_i);
      spi_clk_i = 1'b1;
      repeat (H) @(negedge clk_i);
      spi_clk_i = 1'b0;
      if (gap_every != 0 && ((i + 1) % gap_every) == 0 && i != nbits - 1)
        repeat (3 * 2 * H) @(negedge clk_i);
    end
  endtask

  task automatic settle_and_check(input string name);
    repeat (4 * H) @(negedge clk_i);
    n_checks++;
    if (exp_q.size() != 0 || miso_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d events/%0d responses outstanding, required 0/0",
               name, exp_q.size(), miso_exp_q.size());
    end
    n_checks++;
    if (crc_err_cnt_o != 8'(crc_err_model)) begin
      n_fail++;
      $display("FAIL %s_crc_err_cnt: got %0d, required %0d", name, crc_err_cnt_o, crc_err_model);
    end
    exp_q.delete();
    miso_exp_q.delete();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [7:0] crcf,
                          input logic [15:0] data, input int gap_every, input string name);
    ev_t e;
    if (!CHECK || crcf == crc8_ref(data)) begin
      e.kind = 0; e.addr = addr; e.data = data;
      exp_q.push_back(e);
    end else if (crc_err_model < 255) begin
      crc_err_model++;
    end
    spi_send({1'b1, addr, crcf, data}, 40, gap_every);
    settle_and_check(name);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [15:0] value, input string name);
    ev_t e;
    e.kind = 1; e.addr = addr; e.data = '0;
    exp_q.push_back(e);
    miso_exp_q.push_back({16'h0000, value, crc8_ref(value)});
    rd_value = value;
    rd_active = 1'b1;
    // Bits after the header carry junk: MOSI must be ignored while responding.
    spi_send({1'b0, addr, 24'($urandom)}, 40, 0);
    rd_active = 1'b0;
    settle_and_check(name);
  endtask

  initial begin
    ev_t         e;
    logic [23:0] junk;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    int          kind;

    // Reset state, both during and just after reset.
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({spi_miso_o, bus_addr_o, bus_wdata_o, bus_we_o, bus_re_o, frame_err_o, crc_err_cnt_o} != '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h we=%b re=%b err=%b cnt=%0d, required all 0",
               bus_addr_o, bus_wdata_o, bus_we_o, bus_re_o, frame_err_o, crc_err_cnt_o);
    end
    reset_i = 1'b1;
    settle_and_check("post_reset");

    // Directed scenarios.
    do_write(15'h0010, 8'h00, 16'hA5C3, 0, "write_basic");
    do_read(15'h0010, 16'hA5C3, "read_basic");
    do_write(15'h0123, 8'h00, 16'h1234, 0, "write_badcrc");
    do_write(15'h0123, crc8_ref(16'h1234), 16'h1234, 0, "write_goodcrc");

    // Aborted frame: 10 bits then a long low period.
    e.kind = 2; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
    junk = 24'($urandom);
    spi_send({1'b1, 15'h2AAA, junk}, 10, 0);
    repeat (70) @(negedge clk_i);
    settle_and_check("timeout");
    do_write(15'h4321, crc8_ref(16'hBEEF), 16'hBEEF, 0, "after_timeout");

    // Gaps of three SPI periods between bytes stay under the timeout.
    do_write(15'h0F0F, crc8_ref(16'h5A5A), 16'h5A5A, 8, "gapped_write");

    // Reset in the middle of a header.
    spi_send({1'b1, 15'h7777, 24'h0}, 5, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    crc_err_model = 0;
    n_checks++;
    if ({spi_miso_o, bus_addr_o, bus_wdata_o, bus_we_o, bus_re_o, frame_err_o, crc_err_cnt_o} != '0) begin
      n_fail++;
      $display("FAIL midframe_reset: got addr=%h wdata=%h we=%b re=%b err=%b cnt=%0d, required all 0",
               bus_addr_o, bus_wdata_o, bus_we_o, bus_re_o, frame_err_o, crc_err_cnt_o);
    end
    reset_i = 1'b1;
    repeat (4) @(negedge clk_i);
    do_write(15'h1357, crc8_ref(16'h2468), 16'h2468, 0, "after_reset");

    // Randomized frames.
    for (int n = 0; n < 16; n++) begin
      a = 15'($urandom);
      d = 16'($urandom);
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      do_write(a, crc8_ref(d), d, 0, "rand_write");
      else if (kind == 1) do_write(a, 8'($urandom), d, 0, "rand_write_anycrc");
      else                do_read(a, d, "rand_read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
